// File: rtl/enc3_neuron_seq.sv
// rtl/enc3_neuron_seq.sv - one encoder-3 neuron: shared signed MAC over N_TAPS taps, bias, rescale, saturate, optional ReLU
module enc3_neuron_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 10,
    parameter int N_TAPS     = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int RELU_EN    = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_TAPS*DATA_WIDTH-1:0]   in_vec,
    input  logic [N_TAPS*DATA_WIDTH-1:0]   w_vec,
    input  logic [DATA_WIDTH-1:0]          bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           busy
);

    localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, FINAL, OUT} state_t;

    state_t                         r_state;
    logic [CNT_W-1:0]               r_cnt;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [DATA_WIDTH-1:0]   r_x [N_TAPS];
    logic signed [DATA_WIDTH-1:0]   r_w [N_TAPS];
    logic signed [DATA_WIDTH-1:0]   r_bias;

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_bias_ext;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    logic signed [ACC_WIDTH-1:0]    w_shr;
    logic [DATA_WIDTH-1:0]          w_sat;
    logic [DATA_WIDTH-1:0]          w_result;

    assign w_prod     = r_x[r_cnt] * r_w[r_cnt];
    assign w_prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_WIDTH-DATA_WIDTH){r_bias[DATA_WIDTH-1]}}, r_bias};
    assign w_sum      = r_acc + (w_bias_ext <<< FRAC_BITS);
    // Arithmetic shift floors toward -inf, matching the Q-format rescale.
    assign w_shr      = w_sum >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shr[DATA_WIDTH-1:0];
        if (w_shr > SAT_MAX) begin
            w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_shr < SAT_MIN) begin
            w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        w_result = w_sat;
        if ((RELU_EN != 0) && w_sat[DATA_WIDTH-1]) begin
            w_result = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_bias    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                r_x[i] <= '0;
                r_w[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < N_TAPS; i++) begin
                            r_x[i] <= in_vec[i*DATA_WIDTH +: DATA_WIDTH];
                            r_w[i] <= w_vec[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_bias   <= bias;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(N_TAPS-1)) begin
                        r_state <= FINAL;
                    end
                end
                FINAL: begin
                    out_data  <= w_result;
                    out_valid <= 1'b1;
                    r_state   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
